register_file_param: RTL and testbench

- Parametrised successor to the team's 16x32 CPU register file: configurable width and depth, byte-enabled writes, same-cycle write-to-read bypass, and a PC-mapped read-only register.
- Adds a reset-value register and a hardware bulk-clear sequencer for context reset without a full system reset.
- Sits between decode (read addresses), writeback (write port) and the PC register (pc_in) in the single-cycle/pipelined datapath.

---
 rtl/register_file_param.sv | 128 ++++++++++++
 tb/tb_register_file_param.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/register_file_param.sv
// Parametrised register file: byte-enabled write port with same-cycle bypass,
// PC-mapped read-only register, and a hardware bulk-clear sequencer.
module register_file_param #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int PC_REG   = NUM_REGS - 1,
    parameter int INIT_REG = 12,
    parameter int INIT_VAL = 219999
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     ra1,
    input  logic [ADDR_W-1:0]     ra2,
    output logic [DATA_W-1:0]     rd1,
    output logic [DATA_W-1:0]     rd2,
    input  logic [ADDR_W-1:0]     wa3,
    input  logic [DATA_W-1:0]     wd3,
    input  logic                  we3,
    input  logic [DATA_W/8-1:0]   wbe3,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  clr_done
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W-1:0] PC_ADDR   = ADDR_W'(PC_REG);
    localparam logic [ADDR_W-1:0] INIT_ADDR = ADDR_W'(INIT_REG);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    localparam logic [DATA_W-1:0] INIT_DATA = DATA_W'(INIT_VAL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]      regs_q [NUM_REGS];
    logic [DATA_W-1:0]      regs_d [NUM_REGS];

    logic                   bypass;
    logic [DATA_W-1:0]      merged;

    // The byte-merged write value is shared by the bypass path and the store.
    always_comb begin
        merged = regs_q[wa3];
        for (int unsigned i = 0; i < NB; i++) begin
            if (wbe3[i]) begin
                merged[8*i +: 8] = wd3[8*i +: 8];
            end
        end
        bypass = (state_q == IDLE) && we3 && (wa3 != PC_ADDR);
    end

    always_comb begin
        if (ra1 == PC_ADDR) begin
            rd1 = pc_in;
        end else if (bypass && (ra1 == wa3)) begin
            rd1 = merged;
        end else begin
            rd1 = regs_q[ra1];
        end

        if (ra2 == PC_ADDR) begin
            rd2 = pc_in;
        end else if (bypass && (ra2 == wa3)) begin
            rd2 = merged;
        end else begin
            rd2 = regs_q[ra2];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        regs_d  = regs_q;
        unique case (state_q)
            IDLE: begin
                if (bypass) begin
                    regs_d[wa3] = merged;
                end
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                // PC slot has no storage but still takes its cycle in the sweep.
                if (idx_q != PC_ADDR) begin
                    regs_d[idx_q] = (idx_q == INIT_ADDR) ? INIT_DATA : '0;
                end
                if (idx_q == LAST_ADDR) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            idx_q             <= '0;
            regs_q            <= '{default: '0};
            regs_q[INIT_ADDR] <= INIT_DATA;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            regs_q  <= regs_d;
        end
    end

    assign clr_busy = (state_q == CLEAR);
    assign clr_done = (state_q == DONE);

endmodule

// File: tb/tb_register_file_param.sv
// Directed self-checking bench for register_file_param (default parameters).
module tb_register_file_param;

    logic        clk;
    logic        rst;
    logic [3:0]  ra1, ra2, wa3;
    logic [31:0] rd1, rd2, wd3, pc_in;
    logic        we3;
    logic [3:0]  wbe3;
    logic        clr_req;
    logic        clr_busy, clr_done;

    int unsigned checks;
    int unsigned passed;
    int unsigned cycles;
    int unsigned done_seen;

    localparam logic [31:0] INIT_V = 32'h0003_5B5F;
    localparam logic [31:0] PAT    = 32'hA5A5_A5A5;

    register_file_param #(
        .DATA_W(32),
        .NUM_REGS(16),
        .INIT_REG(12),
        .INIT_VAL(219999)
    ) dut (
        .clk(clk), .rst(rst),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .wa3(wa3), .wd3(wd3), .we3(we3), .wbe3(wbe3),
        .pc_in(pc_in),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        we3 = 1'b1; wa3 = a; wd3 = d; wbe3 = be;
        @(negedge clk);
        we3 = 1'b0; wbe3 = 4'h0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        ra1 = a;
        #1;
        chk(tag, rd1, exp);
    endtask

    initial begin
        checks = 0; passed = 0;
        rst = 1'b0; ra1 = '0; ra2 = '0; wa3 = '0; wd3 = '0; we3 = 1'b0;
        wbe3 = '0; pc_in = 32'h100; clr_req = 1'b0;

        // Reset contents visible while rst is still high
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", {31'b0, clr_busy}, 32'h0);
        chk("rst_done", {31'b0, clr_done}, 32'h0);
        for (int i = 0; i < 15; i++) begin
            rd_chk($sformatf("rst_r%0d", i), 4'(i), (i == 12) ? INIT_V : 32'h0);
        end
        rd_chk("rst_pc", 4'd15, 32'h100);
        @(negedge clk);
        rst = 1'b0;

        // Byte-enabled write with bypass
        @(negedge clk);
        ra1 = 4'd3; we3 = 1'b1; wa3 = 4'd3; wd3 = 32'hFFFF_FFFF; wbe3 = 4'hF;
        #1 chk("byp_full", rd1, 32'hFFFF_FFFF);
        @(negedge clk);
        wd3 = 32'h1234_5678; wbe3 = 4'b0101;
        #1 chk("byp_merge", rd1, 32'hFF34_FF78);
        @(negedge clk);
        we3 = 1'b0; wbe3 = 4'h0;
        #1 chk("be_stored", rd1, 32'hFF34_FF78);
        we3 = 1'b1; wd3 = 32'h0; wbe3 = 4'h0;
        #1 chk("be_zero_byp", rd1, 32'hFF34_FF78);
        @(negedge clk);
        we3 = 1'b0;
        #1 chk("be_zero_store", rd1, 32'hFF34_FF78);

        // PC protection
        pc_in = 32'h40; ra2 = 4'd15; ra1 = 4'd3;
        we3 = 1'b1; wa3 = 4'd15; wd3 = 32'hDEAD_BEEF; wbe3 = 4'hF;
        #1 chk("pc_before", rd2, 32'h40);
        chk("pc_nobyp", rd1, 32'hFF34_FF78);
        @(negedge clk);
        we3 = 1'b0; wbe3 = 4'h0;
        #1 chk("pc_after", rd2, 32'h40);
        rd_chk("pc_r3", 4'd3, 32'hFF34_FF78);
        rd_chk("pc_r14", 4'd14, 32'h0);
        rd_chk("pc_r12", 4'd12, INIT_V);

        // Bulk clear with a write attempted mid-sequence
        for (int i = 0; i < 15; i++) wr(4'(i), PAT, 4'hF);
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        cycles = 0; done_seen = 0;
        while (clr_busy && cycles < 40) begin
            cycles++;
            if (cycles == 2) begin
                we3 = 1'b1; wa3 = 4'd2; wd3 = 32'h1234_5678; wbe3 = 4'hF; ra2 = 4'd2;
                #1 chk("clr_nobyp_r2", rd2, PAT);
            end
            if (cycles == 6) begin
                rd_chk("clr_mid_r10", 4'd10, PAT);
                rd_chk("clr_mid_r5", 4'd5, PAT);
                rd_chk("clr_mid_r0", 4'd0, 32'h0);
                chk("clr_mid_r2", rd2, 32'h0);
                we3 = 1'b0; wbe3 = 4'h0;
            end
            @(negedge clk);
        end
        chk("clr_busy_cycles", cycles, 32'd16);
        chk("clr_done_pulse", {31'b0, clr_done}, 32'h1);
        @(negedge clk);
        chk("clr_done_end", {31'b0, clr_done}, 32'h0);
        chk("clr_busy_end", {31'b0, clr_busy}, 32'h0);
        for (int i = 0; i < 15; i++) begin
            rd_chk($sformatf("clr_r%0d", i), 4'(i), (i == 12) ? INIT_V : 32'h0);
        end

        // Reset during the clear sweep
        wr(4'd12, 32'h55, 4'hF);
        wr(4'd4, 32'h11, 4'hF);
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_busy_pre", {31'b0, clr_busy}, 32'h1);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'b0, clr_busy}, 32'h0);
        chk("abort_done", {31'b0, clr_done}, 32'h0);
        rd_chk("abort_r12", 4'd12, INIT_V);
        rd_chk("abort_r4", 4'd4, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (clr_done) done_seen++;
        end
        chk("abort_no_done", done_seen, 32'd0);

        // Fresh sequence after abort runs full length
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        cycles = 0;
        while (clr_busy && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
        chk("reclr_cycles", cycles, 32'd16);
        chk("reclr_done", {31'b0, clr_done}, 32'h1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
